// File: rtl/dram_arb_pkg.sv
// Shared definitions for the DRAM arbiter: FSM encoding, port indices and
// the legal wait-state range.
package dram_arb_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } arb_state_t;

  localparam int PORT_IF = 0;
  localparam int PORT_LS = 1;

  localparam int LATENCY_MIN = 1;
  localparam int LATENCY_MAX = 15;
  localparam int CNT_BITS    = 4;

  // Out-of-range latencies are clamped so the counter never wraps.
  function automatic logic [CNT_BITS-1:0] wait_init(input int latency);
    int lat;
    lat = latency;
    if (lat < LATENCY_MIN) lat = LATENCY_MIN;
    if (lat > LATENCY_MAX) lat = LATENCY_MAX;
    return CNT_BITS'(lat - 1);
  endfunction

endpackage

// File: rtl/rr_arbiter2.sv
// Combinational two-way round-robin grant: a lone requester wins, a tie goes
// to the port that was not granted last.
module rr_arbiter2
  import dram_arb_pkg::*;
(
  input  logic [1:0] req_valid,
  input  logic       last_grant,
  output logic       grant
);

  always_comb begin
    case (req_valid)
      2'b01:   grant = 1'(PORT_IF);
      2'b10:   grant = 1'(PORT_LS);
      default: grant = ~last_grant;
    endcase
  end

endmodule

// File: rtl/dram_arbiter.sv
// Shares the single-port data DRAM between instruction fetch (port 0) and the
// load/store unit (port 1) with fixed-latency, round-robin transactions.
module dram_arbiter
  import dram_arb_pkg::*;
#(
  parameter int ADDR_BITS = 20,
  parameter int LATENCY   = 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [1:0]           req_valid,
  output logic [1:0]           req_ready,
  input  logic [31:0]          req_addr0,
  input  logic [31:0]          req_addr1,
  input  logic [3:0]           req_we0,
  input  logic [3:0]           req_we1,
  input  logic [31:0]          req_wdata0,
  input  logic [31:0]          req_wdata1,
  output logic [1:0]           resp_valid,
  output logic [31:0]          resp_rdata,
  output logic [ADDR_BITS-1:0] dram_a,
  output logic [3:0]           dram_we,
  output logic [31:0]          dram_d,
  input  logic [31:0]          dram_spo
);

  localparam logic [CNT_BITS-1:0] CNT_INIT = wait_init(LATENCY);

  arb_state_t            state;
  logic                  last_grant;
  logic                  grant;
  logic                  owner;
  logic                  accept;
  logic [CNT_BITS-1:0]   cnt;
  logic [ADDR_BITS-1:0]  addr_q;
  logic [3:0]            we_q;
  logic [31:0]           data_q;
  logic [31:0]           sel_addr;
  logic [3:0]            sel_we;
  logic [31:0]           sel_data;
  logic                  unused_addr_bits;

  rr_arbiter2 u_rr (
    .req_valid  (req_valid),
    .last_grant (last_grant),
    .grant      (grant)
  );

  // NOTE: every signal written in always_comb gets a default first, otherwise
  // the paths that skip the assignment infer a latch.
  always_comb begin
    req_ready = '0;
    if (state == IDLE) req_ready[grant] = req_valid[grant];
  end

  assign accept   = |req_ready;
  assign sel_addr = grant ? req_addr1  : req_addr0;
  assign sel_we   = grant ? req_we1    : req_we0;
  assign sel_data = grant ? req_wdata1 : req_wdata0;

  // Byte offset and bits beyond the DRAM size are dropped: addresses wrap.
  assign unused_addr_bits = ^{sel_addr[31:ADDR_BITS+2], sel_addr[1:0]};

  // The write strobe is decoded from registered state so that reset removes
  // it immediately, without waiting for a clock edge.
  assign dram_a  = addr_q;
  assign dram_d  = data_q;
  assign dram_we = (state == WAIT && cnt == '0) ? we_q : 4'b0000;

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples pre-edge values regardless of statement order.
  // NOTE: the async reset clears every register, including the payload latch,
  // so the DRAM outputs come up at zero.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      last_grant <= 1'b1;
      owner      <= 1'b0;
      cnt        <= '0;
      addr_q     <= '0;
      we_q       <= '0;
      data_q     <= '0;
      resp_valid <= '0;
      resp_rdata <= '0;
    end else begin
      resp_valid <= '0;
      case (state)
        IDLE: begin
          if (accept) begin
            owner      <= grant;
            last_grant <= grant;
            addr_q     <= sel_addr[ADDR_BITS+1:2];
            we_q       <= sel_we;
            data_q     <= sel_data;
            cnt        <= CNT_INIT;
            state      <= WAIT;
          end
        end
        WAIT: begin
          if (cnt == '0) begin
            // spo is sampled on the write edge, so writes return the old word.
            resp_rdata        <= dram_spo;
            resp_valid[owner] <= 1'b1;
            state             <= RESP;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        RESP:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/dram_arbiter.md
# dram_arbiter

Shares the single-port, byte-write-enabled data memory (20-bit word address, combinational read, synchronous write) between two requesters: port 0 (instruction fetch) and port 1 (load/store unit). Each accepted request runs as a fixed-latency transaction: configurable wait states, one DRAM access, then a one-cycle response pulse back to the owner. Round-robin arbitration prevents either port from starving the other. The block sits between the core's memory interfaces and the DRAM model, in both simulation and the FPGA top.

## Interface
- ADDR_BITS, 20, DRAM word-address width.
- LATENCY, 1, wait-state cycles per transaction; legal range 1..15.
- clk  in  1  system clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- req_valid  in  2  per-port request valid; bit i belongs to port i.
- req_ready  out  2  per-port accept.
- req_addr0, req_addr1  in  32 each  byte addresses; bits [1:0] are ignored.
- req_we0, req_we1  in  4 each  byte write enables; all-zero means read.
- req_wdata0, req_wdata1  in  32 each  write data.
- resp_valid  out  2  one-cycle completion pulse to the owning port.
- resp_rdata  out  32  read data, shared by both ports; qualified by resp_valid.
- dram_a  out  ADDR_BITS  DRAM word address.
- dram_we  out  4  DRAM byte write enables.
- dram_d  out  32  DRAM write data.
- dram_spo  in  32  DRAM combinational read data.

## Operation
- FSM states are IDLE, WAIT and RESP.
- **IDLE**
  - Grant goes to the single valid port.
  - If both ports are valid, grant goes to the port that is not last_grant.
  - req_ready[i] = (state==IDLE) && req_valid[i] && grant==i. It is combinational and at most one bit is set.
- **Accept** (valid && ready): latch the address, write enables, write data and the owner. Set last_grant = owner, cnt = LATENCY-1, and go to WAIT.
- **WAIT**
  - dram_a = latched addr[ADDR_BITS+1:2] for every WAIT cycle.
  - dram_d = latched data for every WAIT cycle.
  - dram_we = latched we only when cnt==0; it is 0 in all other cycles.
  - When cnt==0: capture dram_spo into resp_rdata and go to RESP. Otherwise decrement cnt.
- **RESP**: resp_valid[owner]=1 for exactly one cycle, then return to IDLE. No request is accepted during RESP.
- Write transactions return the pre-write word in resp_rdata, because spo is captured on the same edge as the write.
- Address bits above ADDR_BITS+1 are discarded, so addresses wrap modulo 2^ADDR_BITS words. Misaligned requests are not flagged.
- Requester obligation: req_valid must stay asserted, with stable payload, until it is accepted.

## Timing
- Accept in cycle T. WAIT occupies cycles T+1..T+LATENCY. resp_valid is high in cycle T+LATENCY+1.
- The DRAM write commits on the rising edge that closes cycle T+LATENCY.
- Next accept is possible in cycle T+LATENCY+2, giving a throughput of 1 transaction per LATENCY+2 cycles.
- **Reset values:** state=IDLE, last_grant=1 (port 0 wins the first tie), cnt=0, req_ready=0, resp_valid=0, resp_rdata=0, dram_a=0, dram_we=0, dram_d=0.
- **Reset mid-transaction:** the transaction is abandoned, no response is issued, and dram_we drops to 0 immediately (asynchronously). DRAM contents are unaffected unless the write edge has already occurred.
- A port that drops req_valid before it is accepted loses nothing; the tie-break state is unchanged.

## Structure
- Shared package dram_arb_pkg holds:
  - the state encoding (IDLE=2'd0, WAIT=2'd1, RESP=2'd2);
  - the port indices PORT_IF=0 and PORT_LS=1;
  - the LATENCY range limit.
- One sub-module, rr_arbiter2: a combinational 2-way round-robin grant from req_valid and last_grant. It is reused later for MMIO sharing.
- The datapath latch, counter and FSM stay in dram_arbiter.

## Test plan
- **Port 0 read:** DRAM word 0x10 = 0xDEADBEEF, LATENCY=1. Port 0 reads byte addr 0x40 -> accepted in cycle 0, dram_a=0x10 in cycle 1, resp_valid=2'b01 with resp_rdata=0xDEADBEEF in cycle 2.
- **Port 1 byte write:** req_we1=4'b0010, wdata=0x0000AB00, addr 0x44 over old word 0x11223344 -> resp_rdata=0x11223344, then a read of the same address returns 0x1122AB44.
- **Contention:** both ports valid continuously from reset -> grants alternate 0,1,0,1, each resp_valid pulse goes to the matching bit, and neither port waits more than one transaction.
- **Latency sweep:** LATENCY=3, single read -> resp_valid exactly 4 cycles after accept; dram_we is nonzero in exactly one cycle for a write.
- **Reset mid-transaction:** assert rst_n=0 during WAIT of a write with LATENCY=3, cnt=1 -> no resp_valid, DRAM word unchanged, first post-reset tie goes to port 0.
- **Wrap-around:** read byte addr 0x0040_0000 with ADDR_BITS=20 -> dram_a=0 and the data of word 0 is returned.
